// File: rtl/cpu_mem_seq_if.sv
// ----------------------------------------------------------------------------
// cpu_mem_seq_if
// Bundles the command handshake and the byte-wide memory bus of cpu_mem_seq.
//
// Parameters : ADDR_WIDTH (16 or 24), DATA_WIDTH (beat width),
//              MAX_BYTES (largest operand in beats).
// Signals    : enable        - clock qualifier shared by the whole block
//              cmd_*         - command offer (valid/ready handshake)
//              req_rdwr, which_rdwr, addr, data_out, data_in, mem_ready
//                            - memory bus, one beat per accepted mem_ready
//              rsp_valid, rsp_err, rsp_rdata
//                            - completion pulse and load result
// Modports   : master - the sequencer (drives bus and response)
//              slave  - the CPU/memory environment around it
// ----------------------------------------------------------------------------
interface cpu_mem_seq_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BYTES  = 3
);
    logic                              enable;
    logic                              cmd_valid;
    logic                              cmd_ready;
    logic                              cmd_write;
    logic [1:0]                        cmd_len;
    logic [ADDR_WIDTH-1:0]             cmd_addr;
    logic                              cmd_bank_wrap;
    logic [MAX_BYTES*DATA_WIDTH-1:0]   cmd_wdata;
    logic                              req_rdwr;
    logic                              which_rdwr;
    logic [ADDR_WIDTH-1:0]             addr;
    logic [DATA_WIDTH-1:0]             data_out;
    logic [DATA_WIDTH-1:0]             data_in;
    logic                              mem_ready;
    logic                              rsp_valid;
    logic                              rsp_err;
    logic [MAX_BYTES*DATA_WIDTH-1:0]   rsp_rdata;

    modport master (
        input  enable, cmd_valid, cmd_write, cmd_len, cmd_addr, cmd_bank_wrap,
               cmd_wdata, data_in, mem_ready,
        output cmd_ready, req_rdwr, which_rdwr, addr, data_out,
               rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        output enable, cmd_valid, cmd_write, cmd_len, cmd_addr, cmd_bank_wrap,
               cmd_wdata, data_in, mem_ready,
        input  cmd_ready, req_rdwr, which_rdwr, addr, data_out,
               rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/cpu_mem_seq.sv
// ----------------------------------------------------------------------------
// cpu_mem_seq
// Breaks a 1..MAX_BYTES-byte load/store command into byte beats on a simple
// request/ready memory bus, little-endian, one beat per mem_ready. Illegal
// lengths are accepted and answered with an error response and no bus traffic.
//
// Ports : clk  - sole clock, rising edge
//         rst  - asynchronous reset, active low
//         bus  - cpu_mem_seq_if.master (command, memory bus, response,
//                and the enable clock qualifier)
// ----------------------------------------------------------------------------
module cpu_mem_seq #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BYTES  = 3
) (
    input  logic          clk,
    input  logic          rst,
    cpu_mem_seq_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic ENUM__CPU_WH_RDWR__READ  = 1'b0;
    localparam logic ENUM__CPU_WH_RDWR__WRITE = 1'b1;

    localparam int WD_W = MAX_BYTES * DATA_WIDTH;
    // Bits that take part in the bank-wrap increment.
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(32'h0000_FFFF);

    logic [1:0]            state;
    logic                  lat_write;
    logic                  lat_wrap;
    logic [1:0]            lat_len;
    logic [1:0]            idx;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [WD_W-1:0]       lat_wdata;
    logic [WD_W-1:0]       rdata_q;
    logic                  err_q;

    logic                  len_ok;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] addr_next;

    always_comb begin
        len_ok   = (bus.cmd_len != 2'd0) && (int'(bus.cmd_len) <= MAX_BYTES);
        addr_inc = cur_addr + ADDR_WIDTH'(1);
        // Bank wrap keeps the bits above 15; with a 16-bit bus ~LOW_MASK is
        // zero, so both modes collapse to the plain increment.
        addr_next = lat_wrap ? ((cur_addr & ~LOW_MASK) | (addr_inc & LOW_MASK))
                             : addr_inc;
    end

    // Bus outputs are decoded from state, so an asynchronous reset drops
    // req_rdwr in the same cycle and enable=0 freezes them with the state.
    assign bus.cmd_ready  = bus.enable && (state == IDLE);
    assign bus.req_rdwr   = (state == ACCESS);
    assign bus.which_rdwr = lat_write;
    assign bus.addr       = cur_addr;
    assign bus.rsp_valid  = (state == DONE);
    assign bus.rsp_err    = err_q;
    assign bus.rsp_rdata  = rdata_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bus.data_out = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (int'(idx) == i) bus.data_out = lat_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_write <= ENUM__CPU_WH_RDWR__READ;
            lat_wrap  <= 1'b0;
            lat_len   <= 2'd0;
            idx       <= 2'd0;
            cur_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else if (bus.enable) begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        lat_write <= bus.cmd_write ? ENUM__CPU_WH_RDWR__WRITE
                                                   : ENUM__CPU_WH_RDWR__READ;
                        lat_wrap  <= bus.cmd_bank_wrap;
                        lat_len   <= bus.cmd_len;
                        cur_addr  <= bus.cmd_addr;
                        lat_wdata <= bus.cmd_wdata;
                        idx       <= 2'd0;
                        rdata_q   <= '0;
                        err_q     <= !len_ok;
                        state     <= len_ok ? ACCESS : DONE;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        for (int i = 0; i < MAX_BYTES; i++) begin
                            if (!lat_write && int'(idx) == i)
                                rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.data_in;
                        end
                        idx      <= idx + 2'd1;
                        cur_addr <= addr_next;
                        if (idx == lat_len - 2'd1) state <= DONE;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mem_seq.sv
// ----------------------------------------------------------------------------
// tb_cpu_mem_seq
// Three builds of cpu_mem_seq share one stimulus set; only the selected one
// sees cmd_valid. Build 0: 16-bit/3 bytes, build 1: 24-bit/3 bytes,
// build 2: 16-bit/2 bytes. Expected beats, addresses and load results come
// from a small transaction-level model of the command.
// ----------------------------------------------------------------------------
module tb_cpu_mem_seq;
    localparam logic ENUM__CPU_WH_RDWR__READ  = 1'b0;
    localparam logic ENUM__CPU_WH_RDWR__WRITE = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, cmd_valid, cmd_write, cmd_bank_wrap, mem_ready;
    logic [1:0]  cmd_len;
    logic [23:0] cmd_addr, cmd_wdata;
    logic [7:0]  data_in;
    int          sel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_mem_seq_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_BYTES(3)) if_d ();
    cpu_mem_seq_if #(.ADDR_WIDTH(24), .DATA_WIDTH(8), .MAX_BYTES(3)) if_w ();
    cpu_mem_seq_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_BYTES(2)) if_s ();

    assign if_d.enable = enable;          assign if_w.enable = enable;          assign if_s.enable = enable;
    assign if_d.cmd_valid = cmd_valid && sel == 0;
    assign if_w.cmd_valid = cmd_valid && sel == 1;
    assign if_s.cmd_valid = cmd_valid && sel == 2;
    assign if_d.cmd_write = cmd_write;    assign if_w.cmd_write = cmd_write;    assign if_s.cmd_write = cmd_write;
    assign if_d.cmd_len = cmd_len;        assign if_w.cmd_len = cmd_len;        assign if_s.cmd_len = cmd_len;
    assign if_d.cmd_addr = cmd_addr[15:0]; assign if_w.cmd_addr = cmd_addr;     assign if_s.cmd_addr = cmd_addr[15:0];
    assign if_d.cmd_bank_wrap = cmd_bank_wrap;
    assign if_w.cmd_bank_wrap = cmd_bank_wrap;
    assign if_s.cmd_bank_wrap = cmd_bank_wrap;
    assign if_d.cmd_wdata = cmd_wdata;    assign if_w.cmd_wdata = cmd_wdata;    assign if_s.cmd_wdata = cmd_wdata[15:0];
    assign if_d.data_in = data_in;        assign if_w.data_in = data_in;        assign if_s.data_in = data_in;
    assign if_d.mem_ready = mem_ready;    assign if_w.mem_ready = mem_ready;    assign if_s.mem_ready = mem_ready;

    cpu_mem_seq #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_BYTES(3)) u_dflt (.clk(clk), .rst(rst), .bus(if_d));
    cpu_mem_seq #(.ADDR_WIDTH(24), .DATA_WIDTH(8), .MAX_BYTES(3)) u_wide (.clk(clk), .rst(rst), .bus(if_w));
    cpu_mem_seq #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_BYTES(2)) u_small (.clk(clk), .rst(rst), .bus(if_s));

    // Outputs of the selected build, zero-extended to the widest build.
    logic        o_ready, o_req, o_which, o_valid, o_err;
    logic [23:0] o_addr, o_rdata;
    logic [7:0]  o_dout;

    always_comb begin
        o_ready = if_d.cmd_ready;  o_req = if_d.req_rdwr;     o_which = if_d.which_rdwr;
        o_valid = if_d.rsp_valid;  o_err = if_d.rsp_err;      o_dout  = if_d.data_out;
        o_addr  = 24'(if_d.addr);  o_rdata = if_d.rsp_rdata;
        if (sel == 1) begin
            o_ready = if_w.cmd_ready;  o_req = if_w.req_rdwr;  o_which = if_w.which_rdwr;
            o_valid = if_w.rsp_valid;  o_err = if_w.rsp_err;   o_dout  = if_w.data_out;
            o_addr  = if_w.addr;       o_rdata = if_w.rsp_rdata;
        end else if (sel == 2) begin
            o_ready = if_s.cmd_ready;  o_req = if_s.req_rdwr;  o_which = if_s.which_rdwr;
            o_valid = if_s.rsp_valid;  o_err = if_s.rsp_err;   o_dout  = if_s.data_out;
            o_addr  = 24'(if_s.addr);  o_rdata = 24'(if_s.rsp_rdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (build %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    // Address of beat i: linear increment, or low-16-bit wrap with the bank kept.
    function automatic logic [23:0] exp_addr(input int aw, input logic [23:0] base,
                                             input logic wrap, input int i);
        logic [23:0] lin;
        lin = base + 24'(i);
        if (aw == 16) return {8'h00, lin[15:0]};
        if (wrap)     return {base[23:16], lin[15:0]};
        return lin;
    endfunction

    // Issues one command and follows it to the end of its response.
    // rnd=1: random enable/mem_ready/data_in; otherwise the patterns give
    // enable and mem_ready per access cycle and rd gives the load bytes.
    task automatic run_cmd(input logic wr, input logic [1:0] len, input logic [23:0] ad,
                           input logic wrap, input logic [23:0] wd, input logic [23:0] rd,
                           input bit rnd, input logic [15:0] en_pat, input logic [15:0] rdy_pat);
        int          aw, mb, beat, cyc;
        logic [23:0] base, exp_rdata;
        bit          legal;
        logic        e, r;
        aw        = (sel == 1) ? 24 : 16;
        mb        = (sel == 2) ? 2 : 3;
        base      = (aw == 16) ? {8'h00, ad[15:0]} : ad;
        legal     = (len != 2'd0) && (int'(len) <= mb);
        exp_rdata = '0;
        beat      = 0;
        cyc       = 0;
        @(negedge clk);
        check("ready_idle", o_ready, 1);
        cmd_write = wr; cmd_len = len; cmd_addr = ad; cmd_bank_wrap = wrap;
        cmd_wdata = wd; cmd_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = 24'($urandom); cmd_wdata = 24'($urandom);
        while (legal && beat < int'(len) && cyc < 200) begin
            check("req", o_req, 1);
            check("addr", o_addr, exp_addr(aw, base, wrap, beat));
            check("which", o_which, wr ? ENUM__CPU_WH_RDWR__WRITE : ENUM__CPU_WH_RDWR__READ);
            check("ready_busy", o_ready, 0);
            check("valid_busy", o_valid, 0);
            if (wr) check("dout", o_dout, wd[beat*8 +: 8]);
            if (rnd) begin
                e = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) != 0);
            end else begin
                e = (cyc < 16) ? en_pat[cyc] : 1'b1;
                r = (cyc < 16) ? rdy_pat[cyc] : 1'b1;
            end
            enable    = e;
            mem_ready = r;
            data_in   = (rnd || !e || !r) ? 8'($urandom) : rd[beat*8 +: 8];
            if (e && r) begin
                if (!wr) exp_rdata[beat*8 +: 8] = data_in;
                beat++;
            end
            cyc++;
            @(negedge clk);
        end
        check("beats", beat, legal ? 32'(len) : 0);
        check("req_done", o_req, 0);
        check("valid", o_valid, 1);
        check("err", o_err, legal ? 0 : 1);
        check("rdata", o_rdata, exp_rdata);
        check("ready_done", o_ready, 0);
        enable = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check("valid_frozen", o_valid, 1);
        check("req_frozen", o_req, 0);
        enable = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        check("valid_drop", o_valid, 0);
        check("ready_back", o_ready, 1);
        check("rdata_hold", o_rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_len = 2'd0;
        cmd_addr = '0; cmd_bank_wrap = 1'b0; cmd_wdata = '0; data_in = '0;
        mem_ready = 1'b0; sel = 0;
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_req", o_req, 0);
            check("rst_which", o_which, ENUM__CPU_WH_RDWR__READ);
            check("rst_addr", o_addr, 0);
            check("rst_dout", o_dout, 0);
            check("rst_valid", o_valid, 0);
            check("rst_err", o_err, 0);
            check("rst_rdata", o_rdata, 0);
            check("rst_ready", o_ready, 1);
        end
        @(negedge clk);
        rst = 1'b1;

        // 2-beat load, back-to-back ready.
        sel = 0; run_cmd(1'b0, 2'd2, 24'h001234, 1'b0, 24'h0, 24'h00CDAB, 1'b0, 16'hFFFF, 16'hFFFF);
        // 3-beat store across the 64K boundary, bank wrap on and off.
        sel = 1; run_cmd(1'b1, 2'd3, 24'h12FFFF, 1'b1, 24'h332211, 24'h0, 1'b0, 16'hFFFF, 16'hFFFF);
        sel = 1; run_cmd(1'b1, 2'd3, 24'h12FFFF, 1'b0, 24'h332211, 24'h0, 1'b0, 16'hFFFF, 16'hFFFF);
        sel = 0; run_cmd(1'b1, 2'd3, 24'h00FFFF, 1'b0, 24'h332211, 24'h0, 1'b0, 16'hFFFF, 16'hFFFF);
        sel = 0; run_cmd(1'b1, 2'd3, 24'h00FFFF, 1'b1, 24'h332211, 24'h0, 1'b0, 16'hFFFF, 16'hFFFF);
        // 1-beat load: mem_ready low 3 cycles, then enable low 2 cycles.
        sel = 0; run_cmd(1'b0, 2'd1, 24'h000ABC, 1'b0, 24'h0, 24'h00005A, 1'b0, 16'hFFE7, 16'hFFF8);
        // Illegal lengths.
        sel = 0; run_cmd(1'b0, 2'd0, 24'h000100, 1'b0, 24'h0, 24'h0, 1'b0, 16'hFFFF, 16'hFFFF);
        sel = 2; run_cmd(1'b0, 2'd3, 24'h000200, 1'b0, 24'h0, 24'h0, 1'b0, 16'hFFFF, 16'hFFFF);
        sel = 1; run_cmd(1'b1, 2'd0, 24'h300000, 1'b1, 24'h445566, 24'h0, 1'b0, 16'hFFFF, 16'hFFFF);

        // Reset during the 2nd beat of a 3-beat load.
        sel = 1;
        @(negedge clk);
        cmd_write = 1'b0; cmd_len = 2'd3; cmd_addr = 24'h123456; cmd_bank_wrap = 1'b0;
        cmd_valid = 1'b1; mem_ready = 1'b1; enable = 1'b1; data_in = 8'h77;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_beat0_addr", o_addr, 24'h123456);
        @(negedge clk);
        check("abort_beat1_addr", o_addr, 24'h123457);
        check("abort_beat1_req", o_req, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_req", o_req, 0);
        check("abort_valid", o_valid, 0);
        check("abort_rdata", o_rdata, 0);
        check("abort_addr", o_addr, 0);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_abort_valid", o_valid, 0);
            check("post_abort_ready", o_ready, 1);
        end
        run_cmd(1'b0, 2'd3, 24'h12FFFE, 1'b1, 24'h0, 24'hC0B0A0, 1'b0, 16'hFFFF, 16'hFFFF);

        // Random commands on random builds with random stalls.
        repeat (60) begin
            sel = $urandom_range(0, 2);
            run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 24'($urandom),
                    1'($urandom_range(0, 1)), 24'($urandom), 24'($urandom), 1'b1, 16'h0, 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
